// File: rtl/qmac_pkg.sv
// Shared types, widths and helpers for the qmac accumulator.
//   Q, N      : fixed-point format of products, bias and result (sign-magnitude)
//   ACC_W     : accumulator width, N plus GUARD integer guard bits
//   CNT_W     : accepted-term counter width
package qmac_pkg;

    localparam int unsigned Q     = 15;
    localparam int unsigned N     = 32;
    localparam int unsigned GUARD = 8;
    localparam int unsigned ACC_W = N + GUARD;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, ACC, DONE} qmac_state_t;

    // Symmetric accumulator clamp limits: +/-(2^(ACC_W-1)-1)
    localparam logic [ACC_W-1:0] ACC_POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_NEG_MAX = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

    // Largest magnitude representable in the N-bit sign-magnitude result
    localparam logic [N-2:0]     MAG_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    // Sign-magnitude N-bit to ACC_W two's complement; -0 maps to 0.
    function automatic logic [ACC_W-1:0] sm_to_2c(input logic [N-1:0] sm);
        logic [ACC_W-1:0] mag;
        mag = ACC_W'(sm[N-2:0]);
        return sm[N-1] ? (~mag + ACC_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/qmac_sat_sm.sv
// Combinational ACC_W two's complement to N-bit sign-magnitude converter.
// Saturates out-of-range magnitudes, never emits -0.
// Optional feature macro: QMAC_RELU_EN (negative results forced to +0;
// sat_c still reflects the pre-ReLU saturation).
//   acc      : two's complement accumulator value
//   result_c : sign-magnitude result
//   sat_c    : magnitude exceeded the N-bit range
module qmac_sat_sm
    import qmac_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    output logic [N-1:0]     result_c,
    output logic             sat_c
);

    logic             neg;
    logic [ACC_W-1:0] mag;

    // Unsigned magnitude; the most negative value maps correctly to 2^(ACC_W-1)
    always_comb begin
        neg      = acc[ACC_W-1];
        mag      = neg ? (~acc + ACC_W'(1)) : acc;
        sat_c    = (mag > ACC_W'(MAG_MAX));
        result_c = '0;
        if (acc == '0) begin
            result_c = '0;
        end else if (sat_c) begin
            result_c = {neg, MAG_MAX};
        end else begin
            result_c = {neg, mag[N-2:0]};
        end
`ifdef QMAC_RELU_EN
        if (neg) begin
            result_c = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/qmac_accum.sv
// Bias-seeded dot-product accumulator for sign-magnitude qmult products.
// Produces a saturated sign-magnitude sum with a sticky overflow flag.
// Optional feature macro: QMAC_RELU_EN (clamp negative results to +0).
//   i_clk, i_rst_n    : clock, async active-low reset
//   i_bias            : bias, sampled with the first beat of a vector
//   i_prod*           : product beat stream (valid/ready, last, overflow)
//   o_result, o_ovr   : saturated sum and sticky overflow
//   o_count           : terms accepted in the vector (saturating)
//   o_out_valid/i_out_ready : result handshake
module qmac_accum
    import qmac_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_bias,
    input  logic [N-1:0]     i_prod,
    input  logic             i_prod_ovr,
    input  logic             i_prod_last,
    input  logic             i_prod_valid,
    output logic             o_prod_ready,
    output logic [N-1:0]     o_result,
    output logic             o_ovr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    qmac_state_t      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;
    logic [N-1:0]     result_d;
    logic             ovr_d;
    logic [CNT_W-1:0] cnt_out_d;
    logic             valid_d;
    logic             ready_d;

    logic             accept_c;
    logic [ACC_W-1:0] base_c;
    logic [ACC_W-1:0] addend_c;
    logic [ACC_W:0]   sum_c;
    logic             add_ovr_c;
    logic [ACC_W-1:0] sum_sat_c;
    logic [N-1:0]     res_c;
    logic             res_sat_c;

    assign accept_c = i_prod_valid && o_prod_ready;

    // Saturating add; the first beat of a vector adds to the bias instead of acc
    always_comb begin
        base_c    = (state_q == IDLE) ? sm_to_2c(i_bias) : acc_q;
        addend_c  = sm_to_2c(i_prod);
        sum_c     = {base_c[ACC_W-1], base_c} + {addend_c[ACC_W-1], addend_c};
        add_ovr_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
        sum_sat_c = sum_c[ACC_W-1:0];
        if (add_ovr_c) begin
            sum_sat_c = sum_c[ACC_W] ? ACC_NEG_MAX : ACC_POS_MAX;
        end
    end

    // Converts the value being written on the last beat, so the result lands with valid
    qmac_sat_sm u_sat (
        .acc      (sum_sat_c),
        .result_c (res_c),
        .sat_c    (res_sat_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        sticky_d  = sticky_q;
        result_d  = o_result;
        ovr_d     = o_ovr;
        cnt_out_d = o_count;
        valid_d   = o_out_valid;

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    acc_d    = sum_sat_c;
                    count_d  = CNT_W'(1);
                    sticky_d = i_prod_ovr | add_ovr_c;
                    state_d  = i_prod_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept_c) begin
                    acc_d    = sum_sat_c;
                    count_d  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                    sticky_d = sticky_q | i_prod_ovr | add_ovr_c;
                    if (i_prod_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_c && i_prod_last) begin
            result_d  = res_c;
            ovr_d     = sticky_d | res_sat_c;
            cnt_out_d = count_d;
            valid_d   = 1'b1;
        end

        // Ready follows the registered state, so it reopens the cycle after the handshake
        ready_d = (state_d != DONE);
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            count_q      <= '0;
            sticky_q     <= 1'b0;
            o_result     <= '0;
            o_ovr        <= 1'b0;
            o_count      <= '0;
            o_out_valid  <= 1'b0;
            o_prod_ready <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            sticky_q     <= sticky_d;
            o_result     <= result_d;
            o_ovr        <= ovr_d;
            o_count      <= cnt_out_d;
            o_out_valid  <= valid_d;
            o_prod_ready <= ready_d;
        end
    end

endmodule

// File: tb/tb_qmac_accum.sv
// Directed bench for qmac_accum with a scoreboard of expected results.
module tb_qmac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_bias = '0;
    logic [31:0] i_prod = '0;
    logic        i_prod_ovr = 1'b0;
    logic        i_prod_last = 1'b0;
    logic        i_prod_valid = 1'b0;
    logic        o_prod_ready;
    logic [31:0] o_result;
    logic        o_ovr;
    logic [15:0] o_count;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;

    always #5 clk = ~clk;

    qmac_accum dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_bias       (i_bias),
        .i_prod       (i_prod),
        .i_prod_ovr   (i_prod_ovr),
        .i_prod_last  (i_prod_last),
        .i_prod_valid (i_prod_valid),
        .o_prod_ready (o_prod_ready),
        .o_result     (o_result),
        .o_ovr        (o_ovr),
        .o_count      (o_count),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        ovr;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] beat_p[$];
    logic        beat_o[$];
    int          n_vec = 0;
    int          n_err = 0;

    localparam longint LIM = (64'sd1 <<< 39) - 64'sd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint sm2i(input logic [31:0] v);
        longint m;
        m = longint'(v[30:0]);
        return v[31] ? -m : m;
    endfunction

    // Reference model over the queued beats
    function automatic exp_t model(input logic [31:0] bias);
        exp_t   e;
        longint acc, mag;
        logic   st, neg;
        acc = sm2i(bias);
        st  = 1'b0;
        for (int i = 0; i < beat_p.size(); i++) begin
            acc = acc + sm2i(beat_p[i]);
            st  = st | beat_o[i];
            if (acc > LIM) begin
                acc = LIM; st = 1'b1;
            end else if (acc < -LIM - 64'sd1) begin
                acc = -LIM; st = 1'b1;
            end
        end
        neg = (acc < 0);
        mag = neg ? -acc : acc;
        if (acc == 0) begin
            e.res = '0;
        end else if (mag > 64'sh7FFF_FFFF) begin
            e.res = {neg, 31'h7FFF_FFFF};
            st    = 1'b1;
        end else begin
            e.res = {neg, mag[30:0]};
        end
`ifdef QMAC_RELU_EN
        if (neg) e.res = '0;
`else
`endif
        e.ovr = st;
        e.cnt = (beat_p.size() > 65535) ? 16'hFFFF : 16'(beat_p.size());
        return e;
    endfunction

    task automatic drive_beat(input logic [31:0] bias, input logic [31:0] prod,
                              input logic ovr, input logic last);
        int t;
        i_bias = bias; i_prod = prod; i_prod_ovr = ovr; i_prod_last = last;
        i_prod_valid = 1'b1;
        t = 0;
        while (o_prod_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("beat_ready", 64'(o_prod_ready), 64'd1);
        @(posedge clk); #1;
        i_prod_valid = 1'b0; i_prod_last = 1'b0; i_prod_ovr = 1'b0;
    endtask

    // Pushes the expectation (spec constant or model), then streams the queued beats
    task automatic run_vector(input logic [31:0] bias, input int gap,
                              input logic use_const, input exp_t cexp);
        int n;
        sb.push_back(use_const ? cexp : model(bias));
        n = beat_p.size();
        for (int i = 0; i < n; i++) begin
            drive_beat((i == 0) ? bias : 32'hFFFF_FFFF, beat_p[i], beat_o[i], i == n - 1);
            repeat (gap) begin @(posedge clk); #1; end
        end
        beat_p.delete();
        beat_o.delete();
    endtask

    task automatic collect(input string tag, input int hold);
        int          t;
        exp_t        e;
        logic [31:0] r0;
        t = 0;
        while (o_out_valid !== 1'b1 && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_valid"}, 64'(o_out_valid), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_result"}, 64'(o_result), 64'(e.res));
        check({tag, "_ovr"}, 64'(o_ovr), 64'(e.ovr));
        check({tag, "_count"}, 64'(o_count), 64'(e.cnt));
        r0 = o_result;
        if (hold > 0) begin
            i_prod = 32'h0000_8000; i_prod_valid = 1'b1; i_prod_last = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({tag, "_hold_valid"}, 64'(o_out_valid), 64'd1);
                check({tag, "_hold_ready"}, 64'(o_prod_ready), 64'd0);
                check({tag, "_hold_result"}, 64'(o_result), 64'(r0));
                check({tag, "_hold_count"}, 64'(o_count), 64'(e.cnt));
            end
            i_prod_valid = 1'b0; i_prod_last = 1'b0;
        end
        i_out_ready = 1'b1;
        check({tag, "_ready_in_hs"}, 64'(o_prod_ready), 64'd0);
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(o_out_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(o_prod_ready), 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, 64'(o_result), 64'd0);
        check({tag, "_ovr"}, 64'(o_ovr), 64'd0);
        check({tag, "_count"}, 64'(o_count), 64'd0);
        check({tag, "_valid"}, 64'(o_out_valid), 64'd0);
        check({tag, "_ready"}, 64'(o_prod_ready), 64'd0);
    endtask

    initial begin
        exp_t ce;

        // Reset state
        #2;
        check_zero_outputs("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(o_prod_ready), 64'd1);

        // 1: bias 0.5 + 3 x 1.0 = 3.5
        beat_p = '{32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
        beat_o = '{1'b0, 1'b0, 1'b0};
        ce = '{res: 32'h0001_C000, ovr: 1'b0, cnt: 16'd3};
        run_vector(32'h0000_4000, 0, 1'b1, ce);
        collect("t1", 0);

        // 2: single-term vector, bias 0.5 + (-2.0)
        beat_p = '{32'h8001_0000};
        beat_o = '{1'b0};
`ifdef QMAC_RELU_EN
        ce = '{res: 32'h0000_0000, ovr: 1'b0, cnt: 16'd1};
`else
        ce = '{res: 32'h8000_C000, ovr: 1'b0, cnt: 16'd1};
`endif
        run_vector(32'h0000_4000, 0, 1'b1, ce);
        collect("t2", 0);

        // 3: output saturation
        beat_p = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        beat_o = '{1'b0, 1'b0};
        ce = '{res: 32'h7FFF_FFFF, ovr: 1'b1, cnt: 16'd2};
        run_vector(32'h0000_0000, 1, 1'b1, ce);
        collect("t3", 0);

        // 4a: -1.0 + 1.0 gives +0
        beat_p = '{32'h0000_8000};
        beat_o = '{1'b0};
        ce = '{res: 32'h0000_0000, ovr: 1'b0, cnt: 16'd1};
        run_vector(32'h8000_8000, 0, 1'b1, ce);
        collect("t4a", 0);

        // 4b: qmult overflow flag on a middle beat is sticky
        beat_p = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
        beat_o = '{1'b0, 1'b1, 1'b0};
        ce = '{res: 32'h0000_6000, ovr: 1'b1, cnt: 16'd3};
        run_vector(32'h0000_0000, 0, 1'b1, ce);
        collect("t4b", 0);

        // 5: hold the result for 5 cycles while extra beats are offered
        beat_p = '{32'h0000_8000, 32'h8000_2000};
        beat_o = '{1'b0, 1'b0};
        run_vector(32'h0000_1000, 0, 1'b0, ce);
        collect("t5", 5);

        // 6: reset after 2 of 4 beats discards the partial sum
        drive_beat(32'h0001_0000, 32'h0004_0000, 1'b1, 1'b0);
        drive_beat(32'hFFFF_FFFF, 32'h0004_0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_reset", 64'(o_prod_ready), 64'd1);
        beat_p = '{32'h8000_4000, 32'h0000_2000};
        beat_o = '{1'b0, 1'b0};
        ce = '{res: 32'h0000_6000, ovr: 1'b0, cnt: 16'd2};
        run_vector(32'h0000_8000, 0, 1'b1, ce);
        collect("t6", 0);

        // Gapped mixed-sign vector against the model
        for (int i = 0; i < 6; i++) begin
            beat_p.push_back({1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0004_0000))});
            beat_o.push_back(1'b0);
        end
        run_vector(32'h8000_3000, 2, 1'b0, ce);
        collect("rand", 0);

        // Accumulator clamp: 261 maximal terms exceed the 40-bit range
        for (int i = 0; i < 260; i++) begin
            beat_p.push_back(32'h7FFF_FFFF);
            beat_o.push_back(1'b0);
        end
        ce = '{res: 32'h7FFF_FFFF, ovr: 1'b1, cnt: 16'd260};
        run_vector(32'h7FFF_FFFF, 0, 1'b1, ce);
        collect("clamp", 0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
